// File: rtl/cmd_parser.sv
// rtl/cmd_parser.sv - command FIFO header/payload parser for the master-controller engines
//
// Ports:
//   i_clk, i_reset_n            clock, asynchronous active-low reset
//   i_cmd_word, i_cmd_valid     FIFO head word and not-empty flag
//   o_cmd_ready                 pop strobe (word consumed on i_cmd_valid && o_cmd_ready)
//   o_cmd_valid, i_cmd_ack      decoded command handshake towards the engines
//   o_cmd_op, o_cmd_id          decoded opcode and command id
//   o_cmd_payload               payload words, word1 in the low 32 bits, unused words zero
//   o_err_op, o_err_len         one-cycle pulses for unknown opcode / length mismatch
//   o_err_count, i_err_clr      saturating malformed-command count and its synchronous clear
//   o_busy                      high whenever a command is in progress
module cmd_parser #(
  parameter int WORD_WIDTH    = 32,
  parameter int PAYLOAD_WORDS = 3,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                              i_clk,
  input  logic                              i_reset_n,
  input  logic [WORD_WIDTH-1:0]             i_cmd_word,
  input  logic                              i_cmd_valid,
  output logic                              o_cmd_ready,
  output logic                              o_cmd_valid,
  input  logic                              i_cmd_ack,
  output logic [7:0]                        o_cmd_op,
  output logic [7:0]                        o_cmd_id,
  output logic [WORD_WIDTH*PAYLOAD_WORDS-1:0] o_cmd_payload,
  output logic                              o_err_op,
  output logic                              o_err_len,
  output logic [ERR_CNT_WIDTH-1:0]          o_err_count,
  input  logic                              i_err_clr,
  output logic                              o_busy
);

  localparam logic [1:0] ST_HDR     = 2'd0;
  localparam logic [1:0] ST_PAYLOAD = 2'd1;
  localparam logic [1:0] ST_EMIT    = 2'd2;
  localparam logic [1:0] ST_DRAIN   = 2'd3;

  logic [1:0] state;
  logic [6:0] word_idx;
  logic [6:0] last_idx;

  // Header field decode, only meaningful while in ST_HDR.
  logic [7:0] hdr_op;
  logic [7:0] hdr_id;
  logic [7:0] hdr_len;
  logic       op_known;
  logic [7:0] exp_len;
  logic       len_bad;
  logic [6:0] ceil_words;
  logic       hdr_pop;
  logic       err_event;

  assign hdr_op     = i_cmd_word[7:0];
  assign hdr_id     = i_cmd_word[15:8];
  assign hdr_len    = i_cmd_word[23:16];
  assign op_known   = (hdr_op >= 8'hF0) && (hdr_op <= 8'hF4);
  assign exp_len    = ((hdr_op == 8'hF3) || (hdr_op == 8'hF4)) ? 8'd4 : 8'd12;
  assign len_bad    = (hdr_len != exp_len);
  // Malformed commands drain every byte the header claims, rounded up to whole words.
  assign ceil_words = 7'(({1'b0, hdr_len} + 9'd3) >> 2);
  assign hdr_pop    = (state == ST_HDR) && i_cmd_valid;
  assign err_event  = hdr_pop && (!op_known || len_bad);

  assign o_cmd_ready = (state != ST_EMIT);
  assign o_busy      = (state != ST_HDR);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state         <= ST_HDR;
      word_idx      <= '0;
      last_idx      <= '0;
      o_cmd_valid   <= 1'b0;
      o_cmd_op      <= '0;
      o_cmd_id      <= '0;
      o_cmd_payload <= '0;
      o_err_op      <= 1'b0;
      o_err_len     <= 1'b0;
    end else begin
      o_err_op  <= 1'b0;
      o_err_len <= 1'b0;
      case (state)
        ST_HDR: begin
          if (i_cmd_valid) begin
            o_cmd_op      <= hdr_op;
            o_cmd_id      <= hdr_id;
            o_cmd_payload <= '0;
            word_idx      <= '0;
            if (!op_known || len_bad) begin
              // Unknown opcode takes precedence over a length error.
              o_err_op  <= !op_known;
              o_err_len <= op_known;
              last_idx  <= ceil_words - 7'd1;
              state     <= (ceil_words == 7'd0) ? ST_HDR : ST_DRAIN;
            end else begin
              last_idx <= 7'(hdr_len[7:2]) - 7'd1;
              state    <= ST_PAYLOAD;
            end
          end
        end
        ST_PAYLOAD: begin
          if (i_cmd_valid) begin
            for (int i = 0; i < PAYLOAD_WORDS; i++) begin
              if (word_idx == 7'(i)) begin
                o_cmd_payload[i*WORD_WIDTH +: WORD_WIDTH] <= i_cmd_word;
              end
            end
            word_idx <= word_idx + 7'd1;
            if (word_idx == last_idx) begin
              o_cmd_valid <= 1'b1;
              state       <= ST_EMIT;
            end
          end
        end
        ST_EMIT: begin
          if (i_cmd_ack) begin
            o_cmd_valid <= 1'b0;
            state       <= ST_HDR;
          end
        end
        ST_DRAIN: begin
          if (i_cmd_valid) begin
            word_idx <= word_idx + 7'd1;
            if (word_idx == last_idx) begin
              state <= ST_HDR;
            end
          end
        end
        default: state <= ST_HDR;
      endcase
    end
  end

  // Clear wins over the old value but not over a same-cycle error, which counts as one.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_err_count <= '0;
    end else if (i_err_clr) begin
      o_err_count <= err_event ? ERR_CNT_WIDTH'(1) : '0;
    end else if (err_event && (o_err_count != {ERR_CNT_WIDTH{1'b1}})) begin
      o_err_count <= o_err_count + ERR_CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_cmd_parser.sv
// tb/tb_cmd_parser.sv - scoreboard testbench for cmd_parser
module tb_cmd_parser;

  logic        clk = 1'b0;
  logic        i_reset_n;
  logic [31:0] i_cmd_word;
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic        o_cmd_valid;
  logic        i_cmd_ack;
  logic [7:0]  o_cmd_op;
  logic [7:0]  o_cmd_id;
  logic [95:0] o_cmd_payload;
  logic        o_err_op;
  logic        o_err_len;
  logic [7:0]  o_err_count;
  logic        i_err_clr;
  logic        o_busy;

  always #5 clk = ~clk;

  cmd_parser #(.WORD_WIDTH(32), .PAYLOAD_WORDS(3), .ERR_CNT_WIDTH(8)) dut (
    .i_clk        (clk),
    .i_reset_n    (i_reset_n),
    .i_cmd_word   (i_cmd_word),
    .i_cmd_valid  (i_cmd_valid),
    .o_cmd_ready  (o_cmd_ready),
    .o_cmd_valid  (o_cmd_valid),
    .i_cmd_ack    (i_cmd_ack),
    .o_cmd_op     (o_cmd_op),
    .o_cmd_id     (o_cmd_id),
    .o_cmd_payload(o_cmd_payload),
    .o_err_op     (o_err_op),
    .o_err_len    (o_err_len),
    .o_err_count  (o_err_count),
    .i_err_clr    (i_err_clr),
    .o_busy       (o_busy)
  );

  logic [31:0]  fifo_q[$];
  logic [111:0] exp_q[$];   // {op, id, payload}
  int vectors_applied = 0;
  int miscompares     = 0;
  int err_op_seen     = 0;
  int err_len_seen    = 0;
  bit feed_en         = 1'b0;
  bit manual          = 1'b0;
  bit ack_en          = 1'b1;
  bit fire;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
    vectors_applied++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic push_cmd(input logic [31:0] hdr, input logic [31:0] w1, input logic [31:0] w2,
                          input logic [31:0] w3, input int nwords);
    fifo_q.push_back(hdr);
    if (nwords > 0) fifo_q.push_back(w1);
    if (nwords > 1) fifo_q.push_back(w2);
    if (nwords > 2) fifo_q.push_back(w3);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0 || o_busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      vectors_applied++;
      miscompares++;
      $display("FAIL %s: timeout, fifo=%0d pending=%0d required idle", name, fifo_q.size(), exp_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  // FIFO model: presents the head word at negedge, pops it after the posedge that consumed it.
  initial begin
    forever begin
      @(negedge clk);
      if (!manual) begin
        if (feed_en && fifo_q.size() > 0) begin
          i_cmd_valid = 1'b1;
          i_cmd_word  = fifo_q[0];
        end else begin
          i_cmd_valid = 1'b0;
        end
      end
      fire = i_cmd_valid && o_cmd_ready && i_reset_n;
      @(posedge clk);
      if (fire && !manual && fifo_q.size() > 0) void'(fifo_q.pop_front());
    end
  end

  // Monitor: counts error pulses and scores every transferred command against the queue.
  always @(negedge clk) begin
    if (o_err_op) err_op_seen++;
    if (o_err_len) err_len_seen++;
    i_cmd_ack = ack_en;
    if (o_cmd_valid && i_cmd_ack) begin
      if (exp_q.size() == 0) begin
        vectors_applied++;
        miscompares++;
        $display("FAIL unexpected_emit: got op=%h id=%h payload=%h required no command",
                 o_cmd_op, o_cmd_id, o_cmd_payload);
      end else begin
        check("emit", {16'h0, o_cmd_op, o_cmd_id, o_cmd_payload}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares + 1);
    $fatal(1);
  end

  initial begin
    int n;
    int e_op;
    int e_len;
    i_reset_n   = 1'b0;
    i_cmd_word  = '0;
    i_cmd_valid = 1'b0;
    i_cmd_ack   = 1'b0;
    i_err_clr   = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_valid",   o_cmd_valid,   0);
    check("rst_op",      o_cmd_op,      0);
    check("rst_id",      o_cmd_id,      0);
    check("rst_payload", o_cmd_payload, 0);
    check("rst_err",     {o_err_op, o_err_len}, 0);
    check("rst_count",   o_err_count,   0);
    check("rst_busy",    o_busy,        0);
    check("rst_ready",   o_cmd_ready,   1);

    i_reset_n = 1'b1;
    @(negedge clk);

    // Fetch: valid must appear at the negedge right after the third payload pop.
    exp_q.push_back({8'hF0, 8'h05, 96'h00000001_00000210_00001000});
    push_cmd(32'h000C05F0, 32'h00001000, 32'h00000210, 32'h00000001, 3);
    feed_en = 1'b1;
    n = 0;
    while (fifo_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("fetch_valid_latency", o_cmd_valid, 1);
    wait_idle("fetch");

    // Wait-matmul under backpressure with the next header already queued.
    ack_en = 1'b0;
    exp_q.push_back({8'hF4, 8'h09, 96'h0_00000007});
    exp_q.push_back({8'hF1, 8'h06, 96'hCCCC0003_BBBB0002_AAAA0001});
    push_cmd(32'h000409F4, 32'h00000007, 32'h0, 32'h0, 1);
    fifo_q.push_back(32'h000C06F1);
    n = 0;
    while (!o_cmd_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid_seen", o_cmd_valid, 1);
    for (int c = 0; c < 10; c++) begin
      check("bp_hold", {o_cmd_valid, o_cmd_ready, 8'(fifo_q.size()), o_cmd_op, o_cmd_id, o_cmd_payload},
            {1'b1, 1'b0, 8'd1, 8'hF4, 8'h09, 96'h0_00000007});
      @(negedge clk);
    end
    ack_en = 1'b1;
    n = 0;
    while (fifo_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bp_header_popped", 8'(fifo_q.size()), 0);
    fifo_q.push_back(32'hAAAA0001);
    fifo_q.push_back(32'hBBBB0002);
    fifo_q.push_back(32'hCCCC0003);
    wait_idle("backpressure");

    // Unknown opcode, two drained words, then a good fetch.
    e_op  = err_op_seen;
    e_len = err_len_seen;
    push_cmd(32'h000801AA, 32'h11111111, 32'h22222222, 32'h0, 2);
    exp_q.push_back({8'hF0, 8'h07, 96'h00000033_00000022_00000011});
    push_cmd(32'h000C07F0, 32'h00000011, 32'h00000022, 32'h00000033, 3);
    wait_idle("unknown_op");
    check("unk_err_op_pulses", err_op_seen - e_op, 1);
    check("unk_err_len_pulses", err_len_seen - e_len, 0);
    check("unk_err_count", o_err_count, 1);

    // Matmul with len=8: length error, two words drained, nothing emitted.
    e_op  = err_op_seen;
    e_len = err_len_seen;
    push_cmd(32'h000802F2, 32'h33333333, 32'h44444444, 32'h0, 2);
    wait_idle("bad_len");
    check("len_err_len_pulses", err_len_seen - e_len, 1);
    check("len_err_op_pulses", err_op_seen - e_op, 0);
    check("len_err_count", o_err_count, 2);

    // Reset after the second payload word of a fetch, then a fresh wait command.
    push_cmd(32'h000C05F0, 32'h00000001, 32'h00000002, 32'h0, 2);
    n = 0;
    while (fifo_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check("abort_busy_before_reset", {o_busy, o_cmd_valid}, 2'b10);
    i_reset_n = 1'b0;
    @(negedge clk);
    check("abort_state", {o_cmd_valid, o_busy, o_cmd_ready, o_err_count}, {1'b0, 1'b0, 1'b1, 8'd0});
    i_reset_n = 1'b1;
    @(negedge clk);
    exp_q.push_back({8'hF3, 8'h13, 96'h0_DEADBEEF});
    push_cmd(32'h000413F3, 32'hDEADBEEF, 32'h0, 32'h0, 1);
    wait_idle("after_reset");

    // Counter saturation: 256 unknown-op headers with len=0 drain nothing.
    e_op = err_op_seen;
    for (int b = 0; b < 256; b++) fifo_q.push_back(32'h000000AA);
    wait_idle("saturate");
    check("sat_err_op_pulses", err_op_seen - e_op, 256);
    check("sat_count", o_err_count, 255);

    // Clear coinciding with an error leaves a count of one.
    manual = 1'b1;
    @(negedge clk);
    i_cmd_word  = 32'h000000AA;
    i_cmd_valid = 1'b1;
    i_err_clr   = 1'b1;
    @(negedge clk);
    i_cmd_valid = 1'b0;
    i_err_clr   = 1'b0;
    check("clr_with_err", o_err_count, 1);
    @(negedge clk);
    i_err_clr = 1'b1;
    @(negedge clk);
    i_err_clr = 1'b0;
    check("clr_alone", o_err_count, 0);
    manual = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
